// File: rtl/spi_slave_sync.sv
// spi_slave_sync
//   SPI slave that runs entirely on the system clock. SCK, MOSI and SS_N are
//   oversampled through two-flop synchronizers. SCK has a third flop so that
//   its edges can be detected. One byte is shifted in and one byte is shifted
//   out, MSB first, per 8 SCK cycles. All four CPOL/CPHA modes are supported.
//
// Ports
//   clk_i, rstn_i          system clock, asynchronous active-low reset
//   cpol_i, cpha_i         SPI mode; change only while ss_n_i is high
//   sck_i, mosi_i, ss_n_i  asynchronous SPI pins from the master
//   miso_o                 registered slave-out data (never tristated)
//   tx_data_i, tx_valid_i  byte for the single-entry transmit buffer
//   tx_ready_o             transmit buffer empty
//   tx_udr_o               pulse: a byte load found the buffer empty, 0xFF sent
//   rx_data_o              last complete received byte
//   rx_valid_o             pulse: rx_data_o has just been updated
//
// Handshake: a byte is transferred into the transmit buffer on any clk_i edge
// where tx_valid_i and tx_ready_o are both high. tx_valid_i while tx_ready_o
// is low is ignored and must be held or re-presented by the writer.
// tx_ready_o depends only on internal state, never on tx_valid_i.

module spi_slave_sync (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       ss_n_i,
  output logic       miso_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_udr_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o
);

  // [1] is the synchronized value; [2] is its previous value.
  logic [2:0] sck_sync;
  logic [1:0] mosi_sync;
  logic [2:0] ss_sync;

  logic [7:0] rxsr;
  logic [7:0] txsr;
  logic [2:0] bit_cnt;
  logic [7:0] tx_buf;
  logic       tx_full;

  logic sck_cur, sck_prev, ss_cur, ss_prev, mosi_s;
  logic lead, trail, edge_en, sample_edge, shift_edge, ss_fall, load_pt;
  logic wr_accept;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sck_sync  <= 3'b000;
      mosi_sync <= 2'b00;
      ss_sync   <= 3'b111;
    end else begin
      sck_sync  <= {sck_sync[1:0], sck_i};
      mosi_sync <= {mosi_sync[0], mosi_i};
      ss_sync   <= {ss_sync[1:0], ss_n_i};
    end
  end

  assign sck_cur  = sck_sync[1];
  assign sck_prev = sck_sync[2];
  assign ss_cur   = ss_sync[1];
  assign ss_prev  = ss_sync[2];
  assign mosi_s   = mosi_sync[1];

  assign lead  = (sck_prev == cpol_i) && (sck_cur != cpol_i);
  assign trail = (sck_prev != cpol_i) && (sck_cur == cpol_i);

  // SCK edges count only once select has been low for a full cycle. The SCK
  // synchronizer leaves reset at 0. With cpol=1 it would otherwise report a
  // false trailing edge at the same moment that select first reads low.
  assign edge_en     = !ss_cur && !ss_prev;
  assign sample_edge = edge_en && (cpha_i ? trail : lead);
  assign shift_edge  = edge_en && (cpha_i ? lead : trail);
  assign ss_fall     = ss_prev && !ss_cur;

  // With cpha=0 the first bit must be on MISO before the first SCK edge, so
  // the select falling edge also acts as a load point.
  assign load_pt = (shift_edge && (bit_cnt == 3'd0)) || (!cpha_i && ss_fall);

  assign tx_ready_o = !tx_full;
  assign wr_accept  = tx_valid_i && tx_ready_o;

  // Shift registers, bit counter and receive outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rxsr       <= 8'h00;
      txsr       <= 8'hFF;
      bit_cnt    <= 3'd0;
      rx_data_o  <= 8'h00;
      rx_valid_o <= 1'b0;
      tx_udr_o   <= 1'b0;
      miso_o     <= 1'b1;
    end else begin
      rx_valid_o <= 1'b0;
      tx_udr_o   <= 1'b0;
      miso_o     <= txsr[7];
      if (ss_cur) begin
        // Deselected: discard any partial byte and idle MISO high.
        rxsr    <= 8'h00;
        txsr    <= 8'hFF;
        bit_cnt <= 3'd0;
      end else begin
        if (sample_edge) begin
          rxsr    <= {rxsr[6:0], mosi_s};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_o  <= {rxsr[6:0], mosi_s};
            rx_valid_o <= 1'b1;
          end
        end
        if (load_pt) begin
          if (tx_full) begin
            txsr <= tx_buf;
          end else begin
            txsr     <= 8'hFF;
            tx_udr_o <= 1'b1;
          end
        end else if (shift_edge) begin
          txsr <= {txsr[6:0], 1'b1};
        end
      end
    end
  end

  // Single-entry transmit buffer. A load point empties the buffer. If the
  // buffer is already empty at a load point, a write in the same cycle is
  // still accepted.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tx_buf  <= 8'h00;
      tx_full <= 1'b0;
    end else if (load_pt && tx_full) begin
      tx_full <= 1'b0;
    end else if (wr_accept) begin
      tx_buf  <= tx_data_i;
      tx_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync
//   Directed bench for spi_slave_sync. A table of single-byte transfers is
//   run across the SPI modes. Hand-written sequences then cover back-to-back
//   bytes, a write to a full buffer, an aborted byte and a mid-byte reset.

module tb_spi_slave_sync;

  localparam int H = 6;  // SCK half period in clk cycles

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_udr;
  logic [7:0] rx_data;
  logic       rx_valid;

  spi_slave_sync dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .cpol_i     (cpol),
    .cpha_i     (cpha),
    .sck_i      (sck),
    .mosi_i     (mosi),
    .ss_n_i     (ss_n),
    .miso_o     (miso),
    .tx_data_i  (tx_data),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .tx_udr_o   (tx_udr),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- monitor ----------------
  logic [7:0] rx_log [0:63];
  int         udr_at_rx [0:63];
  int         rx_n = 0;
  int         udr_n = 0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_n[5:0]]    <= rx_data;
      udr_at_rx[rx_n[5:0]] <= udr_n;
      rx_n                 <= rx_n + 1;
    end
    if (tx_udr) udr_n <= udr_n + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  int rd_idx = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic sb_check(input string name);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < rx_n) chk(name, {24'h0, rx_log[rd_idx[5:0]]}, {24'h0, e});
      else chk({name, "_count"}, rx_n, rd_idx + 1);
      rd_idx++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic [1:0] mode);
    ss_n = 1'b1;
    wait_clk(4);
    cpol = mode[1];
    cpha = mode[0];
    sck  = mode[1];
    wait_clk(8);
  endtask

  task automatic write_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  // Master side of one byte (or the first nbits of it). The master samples
  // MISO on its own sample edge, using the value present just before it
  // toggles SCK.
  task automatic spi_xfer(input logic [7:0] mo, output logic [7:0] mi,
                          input int nbits, input bit drop_ss, input bit raise_ss);
    mi = 8'h00;
    if (drop_ss) begin
      ss_n = 1'b0;
      wait_clk(H);
    end
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        wait_clk(H);
        mi[i] = miso;
        sck = ~cpol;
        wait_clk(H);
        sck = cpol;
      end else begin
        wait_clk(H);
        sck  = ~cpol;
        mosi = mo[i];
        wait_clk(H);
        mi[i] = miso;
        sck = cpol;
      end
    end
    wait_clk(H);
    if (raise_ss) begin
      ss_n = 1'b1;
      wait_clk(H);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0] mode;
    logic [7:0] preload;
    logic [7:0] mosi_byte;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs [5];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passes, checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] got;
    int r0, u0;

    vecs[0] = '{2'd0, 8'hA5, 8'h0D, 8'h0D, 8'hA5};
    vecs[1] = '{2'd1, 8'h3C, 8'hC3, 8'hC3, 8'h3C};
    vecs[2] = '{2'd2, 8'h3C, 8'hC3, 8'hC3, 8'h3C};
    vecs[3] = '{2'd3, 8'h3C, 8'hC3, 8'hC3, 8'h3C};
    vecs[4] = '{2'd2, 8'h81, 8'h7E, 8'h7E, 8'h81};

    // reset state
    wait_clk(3);
    chk("reset_miso", miso, 1);
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_tx_udr", tx_udr, 0);
    rstn = 1'b1;
    wait_clk(4);

    // table-driven single-byte transfers
    for (int v = 0; v < 5; v++) begin
      set_mode(vecs[v].mode);
      write_tx(vecs[v].preload);
      chk("vec_tx_ready_after_write", tx_ready, 0);
      r0 = rx_n;
      exp_q.push_back(vecs[v].exp_rx);
      spi_xfer(vecs[v].mosi_byte, got, 8, 1'b1, 1'b1);
      chk("vec_master_rx", got, vecs[v].exp_miso);
      chk("vec_rx_valid_pulses", rx_n - r0, 1);
      sb_check("vec_rx_data");
      chk("vec_tx_ready_after_byte", tx_ready, 1);
    end

    // four back-to-back bytes, select held low, only the first preloaded
    set_mode(2'd0);
    write_tx(8'h96);
    u0 = udr_n;
    r0 = rx_n;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h0D);
    spi_xfer(8'h0D, got, 8, 1'b1, 1'b0);
    chk("b2b_byte1", got, 8'h96);
    spi_xfer(8'h0D, got, 8, 1'b0, 1'b0);
    chk("b2b_byte2", got, 8'hFF);
    spi_xfer(8'h0D, got, 8, 1'b0, 1'b0);
    chk("b2b_byte3", got, 8'hFF);
    spi_xfer(8'h0D, got, 8, 1'b0, 1'b1);
    chk("b2b_byte4", got, 8'hFF);
    chk("b2b_rx_valid_pulses", rx_n - r0, 4);
    // The load at the end of byte 4 also underflows. Count only up to the
    // fourth received byte: the loads for bytes 2..4.
    if (rx_n - r0 >= 4) chk("b2b_udr_pulses", udr_at_rx[(r0 + 3) & 63] - u0, 3);
    else chk("b2b_udr_rx_missing", rx_n - r0, 4);
    sb_check("b2b_rx_data");

    // second write while the buffer is full is dropped
    set_mode(2'd0);
    write_tx(8'h11);
    write_tx(8'h22);
    chk("full_tx_ready", tx_ready, 0);
    exp_q.push_back(8'h77);
    spi_xfer(8'h77, got, 8, 1'b1, 1'b1);
    chk("full_master_rx", got, 8'h11);
    exp_q.push_back(8'h33);
    spi_xfer(8'h33, got, 8, 1'b1, 1'b1);
    chk("full_dropped_not_sent", got, 8'hFF);
    sb_check("full_rx_data");

    // aborted byte: select raised after 4 SCK cycles
    set_mode(2'd0);
    r0 = rx_n;
    spi_xfer(8'hF0, got, 4, 1'b1, 1'b1);
    chk("abort_no_rx_valid", rx_n - r0, 0);
    exp_q.push_back(8'h5A);
    spi_xfer(8'h5A, got, 8, 1'b1, 1'b1);
    chk("abort_next_rx_valid", rx_n - r0, 1);
    sb_check("abort_rx_data");

    // reset asserted mid-byte
    set_mode(2'd0);
    write_tx(8'hC6);
    spi_xfer(8'h00, got, 3, 1'b1, 1'b0);
    write_tx(8'h99);
    chk("rst_tx_ready_before", tx_ready, 0);
    chk("rst_miso_before", miso, 0);
    rstn = 1'b0;
    #1;
    chk("rst_miso_immediate", miso, 1);
    chk("rst_tx_ready_immediate", tx_ready, 1);
    wait_clk(2);
    ss_n = 1'b1;
    sck  = 1'b0;
    wait_clk(2);
    rstn = 1'b1;
    wait_clk(6);
    write_tx(8'h42);
    exp_q.push_back(8'h81);
    spi_xfer(8'h81, got, 8, 1'b1, 1'b1);
    chk("rst_master_rx", got, 8'h42);
    sb_check("rst_rx_data");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
